// File: rtl/ex_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with divide-by-zero and signed-overflow answered without iterating.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush,
  input  logic [2:0]            aluop,
  input  logic [XLEN-1:0]       opv1,
  input  logic [XLEN-1:0]       opv2,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  we_i,
  output logic                  valid_o,
  output logic [XLEN-1:0]       wdata,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic                  we_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic [2:0]              r_op;
  logic [REG_ADDR_W-1:0]   r_waddr;
  logic                    r_we;
  logic                    r_neg_res;
  logic                    r_neg_rem;
  logic [XLEN-1:0]         r_dvsr;
  logic [2*XLEN-1:0]       r_acc;
  logic [XLEN-1:0]         r_rem;
  logic [XLEN-1:0]         r_wdata;
  logic [REG_ADDR_W-1:0]   r_waddr_o;
  logic                    r_we_o;

  logic                    w_accept, w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0]         w_mag1, w_mag2;
  logic                    w_div_zero, w_ovf, w_fast;
  logic [XLEN-1:0]         w_fast_res;
  logic [XLEN:0]           w_mul_sum, w_div_shift, w_div_diff;
  logic                    w_q_bit;
  logic [2*XLEN-1:0]       w_prod_fix;
  logic [XLEN-1:0]         w_quo_fix, w_rem_fix, w_fix_res;

  assign w_accept = valid_i && ready_o && !flush;

  assign w_sgn1 = (aluop == OP_MULH) || (aluop == OP_MULHSU) || (aluop == OP_DIV) || (aluop == OP_REM);
  assign w_sgn2 = (aluop == OP_MULH) || (aluop == OP_DIV) || (aluop == OP_REM);
  assign w_neg1 = w_sgn1 && opv1[XLEN-1];
  assign w_neg2 = w_sgn2 && opv2[XLEN-1];
  assign w_mag1 = w_neg1 ? -opv1 : opv1;
  assign w_mag2 = w_neg2 ? -opv2 : opv2;

  // aluop[1] separates REM* from DIV* among the divide codes.
  assign w_div_zero = aluop[2] && (opv2 == '0);
  assign w_ovf      = ((aluop == OP_DIV) || (aluop == OP_REM)) &&
                      (opv1 == {1'b1, {(XLEN-1){1'b0}}}) && (opv2 == '1);
  assign w_fast     = w_div_zero || w_ovf;
  assign w_fast_res = w_div_zero ? (aluop[1] ? opv1 : '1)
                                 : (aluop[1] ? '0   : opv1);

  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_dvsr};
  assign w_div_shift = {r_rem, r_acc[XLEN-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dvsr};
  assign w_q_bit     = !w_div_diff[XLEN];

  assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
  assign w_quo_fix  = r_neg_res ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:               w_fix_res = w_prod_fix[XLEN-1:0];
      3'b100, 3'b101:       w_fix_res = w_quo_fix;
      3'b110, 3'b111:       w_fix_res = w_rem_fix;
      default:              w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: the whole datapath is reset, so nothing from an interrupted operation survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_waddr   <= '0;
      r_we      <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_dvsr    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_wdata   <= '0;
      r_waddr_o <= '0;
      r_we_o    <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= aluop;
          r_waddr   <= waddr_i;
          r_we      <= we_i;
          r_neg_res <= w_neg1 ^ w_neg2;
          r_neg_rem <= w_neg1;
          r_cnt     <= CNT_W'(XLEN - 1);
          r_rem     <= '0;
          // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
          r_dvsr    <= aluop[2] ? w_mag2 : w_mag1;
          r_acc     <= {{XLEN{1'b0}}, (aluop[2] ? w_mag1 : w_mag2)};
          if (w_fast) begin
            r_wdata   <= w_fast_res;
            r_waddr_o <= waddr_i;
            r_we_o    <= we_i;
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            r_rem <= w_q_bit ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            r_acc <= {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_q_bit};
          end else if (r_acc[0]) begin
            r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
          end else begin
            r_acc <= {1'b0, r_acc[2*XLEN-1:1]};
          end
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_wdata   <= w_fix_res;
          r_waddr_o <= r_waddr;
          r_we_o    <= r_we;
        end
        default: ;
      endcase
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE) && !flush;
  assign we_o    = valid_o && r_we_o;
  assign wdata   = r_wdata;
  assign waddr_o = r_waddr_o;

endmodule
